// File: rtl/regfile_wb_arb_if.sv
// Writeback bus between the two writeback requesters (A = ALU, B = load),
// the arbiter, and the register-file write port.
// Optional read-forwarding signals exist only when REGFILE_FWD_EN is defined.
interface regfile_wb_arb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int RW = $clog2(NREG);

  logic            a_valid;
  logic [RW-1:0]   a_rd;
  logic [XLEN-1:0] a_wd;
  logic            a_ready;

  logic            b_valid;
  logic [RW-1:0]   b_rd;
  logic [XLEN-1:0] b_wd;
  logic            b_ready;

  logic            we;
  logic [RW-1:0]   rd;
  logic [XLEN-1:0] wd;
  logic            init_busy;

`ifdef REGFILE_FWD_EN
  logic [RW-1:0]   rs1, rs2;
  logic [XLEN-1:0] rrs1_in, rrs2_in;
  logic [XLEN-1:0] rrs1_fwd, rrs2_fwd;

  modport master (
    output a_valid, a_rd, a_wd, b_valid, b_rd, b_wd, rs1, rs2, rrs1_in, rrs2_in,
    input  a_ready, b_ready, we, rd, wd, init_busy, rrs1_fwd, rrs2_fwd
  );
  modport slave (
    input  a_valid, a_rd, a_wd, b_valid, b_rd, b_wd, rs1, rs2, rrs1_in, rrs2_in,
    output a_ready, b_ready, we, rd, wd, init_busy, rrs1_fwd, rrs2_fwd
  );
`else
  modport master (
    output a_valid, a_rd, a_wd, b_valid, b_rd, b_wd,
    input  a_ready, b_ready, we, rd, wd, init_busy
  );
  modport slave (
    input  a_valid, a_rd, a_wd, b_valid, b_rd, b_wd,
    output a_ready, b_ready, we, rd, wd, init_busy
  );
`endif
endinterface

// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter.
// After reset it clears every register (INIT), then round-robins between the
// ALU (A) and load (B) writeback ports, one registered write per cycle.
// x0 is never written after the clear.
// Optional macro REGFILE_FWD_EN adds read forwarding from the registered write
// port, covering the cycle between acceptance and commit.
module regfile_wb_arb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic             CLK,
  input  logic             RST_X,
  regfile_wb_arb_if.slave  bus
);
  localparam int RW = $clog2(NREG);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic            we;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] wd;
  } wb_t;

  state_t        state, state_nx;
  logic [RW-1:0] cnt, cnt_nx;
  logic          rr_b, rr_b_nx;   // 1: last grant went to B, so A is favoured
  wb_t           wb_q, wb_nx;
  logic          a_gnt, b_gnt;

  // State, clear counter, round-robin pointer and registered write port.
  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      state <= INIT;
      cnt   <= '0;
      rr_b  <= 1'b1;
      wb_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rr_b  <= rr_b_nx;
      wb_q  <= wb_nx;
    end
  end

  // Next state, grants and next write. Idle cycles hold rd/wd and drop we;
  // an accepted write to x0 is swallowed the same way.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rr_b_nx  = rr_b;
    wb_nx    = wb_q;
    wb_nx.we = 1'b0;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    case (state)
      INIT: begin
        wb_nx  = '{we: 1'b1, rd: cnt, wd: '0};
        cnt_nx = cnt + 1'b1;
        if (cnt == RW'(NREG - 1)) state_nx = RUN;
      end
      RUN: begin
        a_gnt = bus.a_valid && (!bus.b_valid || rr_b);
        b_gnt = bus.b_valid && !a_gnt;
        if (a_gnt) begin
          rr_b_nx = 1'b0;
          if (bus.a_rd != '0) wb_nx = '{we: 1'b1, rd: bus.a_rd, wd: bus.a_wd};
        end else if (b_gnt) begin
          rr_b_nx = 1'b1;
          if (bus.b_rd != '0) wb_nx = '{we: 1'b1, rd: bus.b_rd, wd: bus.b_wd};
        end
      end
    endcase
  end

  assign bus.a_ready   = a_gnt;
  assign bus.b_ready   = b_gnt;
  assign bus.we        = wb_q.we;
  assign bus.rd        = wb_q.rd;
  assign bus.wd        = wb_q.wd;
  assign bus.init_busy = (state == INIT);

`ifdef REGFILE_FWD_EN
  // Bypass the not-yet-committed write onto the read ports; x0 never forwards.
  assign bus.rrs1_fwd = (wb_q.we && bus.rs1 != '0 && wb_q.rd == bus.rs1) ? wb_q.wd : bus.rrs1_in;
  assign bus.rrs2_fwd = (wb_q.we && bus.rs2 != '0 && wb_q.rd == bus.rs2) ? wb_q.wd : bus.rrs2_in;
`endif

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter XLEN, default 32: write-data width.
REQ-002 Parameter NREG, default 32: register count; destination index width is log2(NREG), 5 at default.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST_X  input  1  asynchronous, active-high reset.
REQ-005 a_valid, a_rd[4:0], a_wd[XLEN-1:0]  input: requester A (ALU writeback) offers a write.
REQ-006 a_ready  output  1: A's write is accepted this cycle.
REQ-007 b_valid, b_rd[4:0], b_wd[XLEN-1:0]  input: requester B (load writeback) offers a write.
REQ-008 b_ready  output  1: B's write is accepted this cycle.
REQ-009 we  output  1, rd  output  5, wd  output  XLEN: registered write port driven to the register file.
REQ-010 init_busy  output  1: clear sequence in progress.
REQ-011 With REGFILE_FWD_EN only: rs1, rs2  input  5; rrs1_in, rrs2_in  input  XLEN (register-file read data); rrs1_fwd, rrs2_fwd  output  XLEN.

Function
REQ-012 States: INIT and RUN; reset enters INIT with counter cnt=0.
REQ-013 In INIT, each cycle registers we=1, rd=cnt, wd=0, then increments cnt; a_ready=b_ready=0; init_busy=1.
REQ-014 The write of cnt=NREG-1 moves the block to RUN; INIT lasts exactly NREG cycles after reset release.
REQ-015 In RUN, init_busy=0; a_ready and b_ready are combinational from valids and the rr pointer.
REQ-016 A handshake on a port is valid && ready in the same cycle; at most one port is ready per cycle.
REQ-017 If only one port is valid, that port gets ready.
REQ-018 If both ports are valid, the port not granted last gets ready; rr records the granted port on every handshake.
REQ-019 A handshake in cycle N registers we=1, rd and wd from the winning port, visible in cycle N+1; the register file commits at the end of N+1.
REQ-020 A cycle with no handshake registers we=0; rd and wd hold their previous values.
REQ-021 A handshake with rd=0 is accepted but registers we=0, so x0 is never written after INIT.
REQ-022 Both ports naming the same rd: the loser is written in a later cycle, so the final value is the loser's (last-written-wins).
REQ-023 A requester holds valid, rd and wd stable until ready; the arbiter does not check this.
REQ-024 Sustained throughput is one write per cycle; neither port waits more than one cycle while the other is continuously valid.

Reset
REQ-025 While RST_X=1: we=0, rd=0, wd=0, a_ready=0, b_ready=0, init_busy=1, cnt=0, state=INIT, rr favours A (last grant = B).
REQ-026 RST_X asserted mid-INIT or mid-RUN aborts immediately: no pending write completes, and the clear restarts from cnt=0 after release.
REQ-027 Outputs change only asynchronously on RST_X or on CLK edges, except a_ready/b_ready and the forwarding outputs.

Configuration
REQ-028 Macro REGFILE_FWD_EN defined: rrs1_fwd = wd when we=1, rd=rs1 and rs1!=0, else rrs1_in; rrs2_fwd likewise; this covers the one-cycle gap between acceptance and commit.
REQ-029 Macro REGFILE_FWD_EN undefined: the REQ-011 ports are absent and there is no forwarding logic.

Verification
REQ-030 Reset pulse then release -> init_busy=1 for 32 cycles, we=1 with rd=0..31 and wd=0, then init_busy=0 and we=0.
REQ-031 RUN, a_valid=1 a_rd=5 a_wd=0x11, b idle -> a_ready=1; next cycle we=1 rd=5 wd=0x11.
REQ-032 RUN, both valid continuously (A rd=3 wd=0xA, B rd=4 wd=0xB) from reset -> grants A,B,A,B; the we stream alternates rd 3/4.
REQ-033 RUN, both valid with rd=7 (A wd=1, B wd=2) -> A first, then B; final register 7 = 2.
REQ-034 b_valid=1 b_rd=0 b_wd=0xFF -> b_ready=1; next cycle we=0.
REQ-035 RST_X asserted at cnt=10 -> outputs reset at once; after release the clear restarts at rd=0. With REGFILE_FWD_EN: accepted write rd=9 wd=0x55 and rs1=9 -> rrs1_fwd=0x55 in the we cycle.
